// File: rtl/repair_code_responder.sv
// Repair-code responder: arms on a repair request, checks player entries
// against the latched challenge, and reports pass/fail under attempt/time limits.
//
// Ports:
//   Clk, Reset           - clock, synchronous active-high reset
//   repair_req/challenge - start a repair and the code to match
//   entry/submit         - player code and its submit pulse
//   tick                 - timebase enable for the repair timer
//   gameover_ctrl        - aborts any repair, no result pulse
//   busy, repair_done, repair_fail, attempts_left, timer_left,
//   display_hex, lockout, q_Idle/q_Armed/q_Pass/q_Fail - status outputs
//
// Optional feature macro: REPAIR_LOCKOUT_EN (post-miss submit lockout).

module repair_code_responder #(
    parameter int MAX_ATTEMPTS  = 3,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       repair_req,
    input  logic [3:0] challenge,
    input  logic [3:0] entry,
    input  logic       submit,
    input  logic       tick,
    input  logic       gameover_ctrl,
    output logic       busy,
    output logic       repair_done,
    output logic       repair_fail,
    output logic [1:0] attempts_left,
    output logic [3:0] timer_left,
    output logic [3:0] display_hex,
    output logic       lockout,
    output logic       q_Idle,
    output logic       q_Armed,
    output logic       q_Pass,
    output logic       q_Fail
);

    localparam logic [1:0] LP_ATT = 2'(MAX_ATTEMPTS);
    localparam logic [3:0] LP_TMR = 4'(TIMEOUT_TICKS);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ARMED = 4'b0010,
        ST_PASS  = 4'b0100,
        ST_FAIL  = 4'b1000
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_chal;
    logic [3:0] w_chal_nxt;
    logic [1:0] r_att;
    logic [1:0] w_att_nxt;
    logic [3:0] r_tmr;
    logic [3:0] w_tmr_nxt;

    logic       w_lock_active;
    logic       w_armed;
    logic       w_accept;
    logic       w_match;
    logic       w_wrong;
    logic       w_fail_att;
    logic       w_fail_tmr;

    assign w_armed    = (r_state == ST_ARMED);
    // A submit only counts when the lockout window is closed.
    assign w_accept   = w_armed & submit & ~w_lock_active;
    assign w_match    = w_accept & (entry == r_chal);
    assign w_wrong    = w_accept & (entry != r_chal);
    assign w_fail_att = w_wrong & (r_att == 2'd1);
    assign w_fail_tmr = w_armed & tick & (r_tmr == 4'd1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_chal  <= 4'd0;
            r_att   <= 2'd0;
            r_tmr   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_chal  <= w_chal_nxt;
            r_att   <= w_att_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_chal_nxt  = r_chal;
        w_att_nxt   = r_att;
        w_tmr_nxt   = r_tmr;
        if (gameover_ctrl) begin
            // Abort: return home, counters frozen where they are.
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (repair_req) begin
                        w_chal_nxt  = challenge;
                        w_att_nxt   = LP_ATT;
                        w_tmr_nxt   = LP_TMR;
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_match) begin
                        // A correct entry beats a same-cycle timer expiry.
                        w_state_nxt = ST_PASS;
                    end else begin
                        if (w_wrong && (r_att != 2'd0)) begin
                            w_att_nxt = r_att - 2'd1;
                        end
                        if (tick && (r_tmr != 4'd0)) begin
                            w_tmr_nxt = r_tmr - 4'd1;
                        end
                        if (w_fail_att || w_fail_tmr) begin
                            w_state_nxt = ST_FAIL;
                        end
                    end
                end
                ST_PASS: w_state_nxt = ST_IDLE;
                ST_FAIL: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

`ifdef REPAIR_LOCKOUT_EN
    logic [1:0] r_lock;
    logic [1:0] w_lock_nxt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lock <= 2'd0;
        end else begin
            r_lock <= w_lock_nxt;
        end
    end

    always_comb begin
        w_lock_nxt = r_lock;
        if (w_state_nxt != ST_ARMED) begin
            // Window never survives leaving the armed state.
            w_lock_nxt = 2'd0;
        end else if (w_wrong) begin
            w_lock_nxt = 2'd2;
        end else if (tick && (r_lock != 2'd0)) begin
            w_lock_nxt = r_lock - 2'd1;
        end
    end

    assign w_lock_active = (r_lock != 2'd0);
`else
    assign w_lock_active = 1'b0;
`endif

    assign busy          = (r_state == ST_ARMED);
    assign repair_done   = (r_state == ST_PASS);
    assign repair_fail   = (r_state == ST_FAIL);
    assign attempts_left = r_att;
    assign timer_left    = r_tmr;
    assign display_hex   = (r_state == ST_ARMED) ? r_chal : 4'd0;
    assign lockout       = w_lock_active;
    assign q_Idle        = (r_state == ST_IDLE);
    assign q_Armed       = (r_state == ST_ARMED);
    assign q_Pass        = (r_state == ST_PASS);
    assign q_Fail        = (r_state == ST_FAIL);

endmodule

// File: tb/tb_repair_code_responder.sv
// Testbench for repair_code_responder: directed scenarios plus randomized
// stimulus checked against a behavioural model of the repair rules.

module tb_repair_code_responder;

    localparam int MAXA = 3;
    localparam int TMO  = 10;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       repair_req;
    logic [3:0] challenge;
    logic [3:0] entry;
    logic       submit;
    logic       tick;
    logic       gameover_ctrl;
    logic       busy;
    logic       repair_done;
    logic       repair_fail;
    logic [1:0] attempts_left;
    logic [3:0] timer_left;
    logic [3:0] display_hex;
    logic       lockout;
    logic       q_Idle;
    logic       q_Armed;
    logic       q_Pass;
    logic       q_Fail;

    int n_cmp = 0;
    int n_bad = 0;

    repair_code_responder #(
        .MAX_ATTEMPTS (MAXA),
        .TIMEOUT_TICKS(TMO)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .repair_req   (repair_req),
        .challenge    (challenge),
        .entry        (entry),
        .submit       (submit),
        .tick         (tick),
        .gameover_ctrl(gameover_ctrl),
        .busy         (busy),
        .repair_done  (repair_done),
        .repair_fail  (repair_fail),
        .attempts_left(attempts_left),
        .timer_left   (timer_left),
        .display_hex  (display_hex),
        .lockout      (lockout),
        .q_Idle       (q_Idle),
        .q_Armed      (q_Armed),
        .q_Pass       (q_Pass),
        .q_Fail       (q_Fail)
    );

    always #5 Clk = ~Clk;

    // Behavioural model: phase 0 idle, 1 armed, 2 pass, 3 fail.
    int m_ph;
    int m_chal;
    int m_att;
    int m_tmr;
    int m_lock;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_in();
        repair_req    = 1'b0;
        challenge     = 4'd0;
        entry         = 4'd0;
        submit        = 1'b0;
        tick          = 1'b0;
        gameover_ctrl = 1'b0;
    endtask

    task automatic apply_reset();
        clear_in();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic arm(input logic [3:0] code);
        repair_req = 1'b1;
        challenge  = code;
        step();
        repair_req = 1'b0;
        challenge  = 4'd0;
    endtask

    task automatic model_step();
        bit acc;
        bit fl;
        if (Reset) begin
            m_ph = 0; m_chal = 0; m_att = 0; m_tmr = 0; m_lock = 0;
        end else if (gameover_ctrl) begin
            m_ph = 0; m_lock = 0;
        end else if (m_ph == 0) begin
            if (repair_req) begin
                m_chal = int'(challenge); m_att = MAXA; m_tmr = TMO; m_ph = 1;
            end
        end else if (m_ph == 1) begin
            acc = submit && (m_lock == 0);
            if (acc && int'(entry) == m_chal) begin
                m_ph = 2; m_lock = 0;
            end else begin
                fl = 0;
                if (acc) begin
                    if (m_att == 1) fl = 1;
                    if (m_att > 0) m_att--;
                end
                if (tick) begin
                    if (m_tmr == 1) fl = 1;
                    if (m_tmr > 0) m_tmr--;
                    if (!acc && m_lock > 0) m_lock--;
                end
                if (fl) begin
                    m_ph = 3; m_lock = 0;
                end else if (acc) begin
`ifdef REPAIR_LOCKOUT_EN
                    m_lock = 2;
`endif
                end
            end
        end else begin
            m_ph = 0;
        end
    endtask

    task automatic test_reset();
        clear_in();
        Reset = 1'b1;
        repair_req = 1'b1;
        challenge = 4'hC;
        submit = 1'b1;
        tick = 1'b1;
        step();
        n_cmp++;
        if ({q_Idle, q_Armed, q_Pass, q_Fail} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_state got %b want 1000", {q_Idle, q_Armed, q_Pass, q_Fail});
        end
        n_cmp++;
        if ({busy, repair_done, repair_fail, lockout} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 0000", {busy, repair_done, repair_fail, lockout});
        end
        n_cmp++;
        if ({attempts_left, timer_left, display_hex} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_counters got %h/%h/%h want 0/0/0", attempts_left, timer_left, display_hex);
        end
        apply_reset();
    endtask

    task automatic test_pass();
        apply_reset();
        arm(4'hA);
        n_cmp++;
        if ({busy, display_hex, attempts_left, timer_left} !== {1'b1, 4'hA, 2'd3, 4'd10}) begin
            n_bad++;
            $display("FAIL pass_armed got b%0d hex%h a%0d t%0d want b1 hexa a3 t10", busy, display_hex, attempts_left, timer_left);
        end
        step();
        step();
        submit = 1'b1;
        entry = 4'hA;
        step();
        submit = 1'b0;
        entry = 4'h0;
        n_cmp++;
        if ({repair_done, repair_fail, q_Pass, busy} !== 4'b1010) begin
            n_bad++;
            $display("FAIL pass_done got %b want 1010", {repair_done, repair_fail, q_Pass, busy});
        end
        step();
        n_cmp++;
        if ({q_Idle, repair_done, display_hex} !== {1'b1, 1'b0, 4'h0}) begin
            n_bad++;
            $display("FAIL pass_idle got idle%0d done%0d hex%h want 1 0 0", q_Idle, repair_done, display_hex);
        end
    endtask

    task automatic test_attempts();
        int exp_a;
        apply_reset();
        arm(4'h5);
        exp_a = 3;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (attempts_left !== 2'(exp_a) || !q_Armed) begin
                n_bad++;
                $display("FAIL attempts_%0d got %0d armed%0d want %0d armed1", k, attempts_left, q_Armed, exp_a);
            end
`ifdef REPAIR_LOCKOUT_EN
            if (k > 0) begin
                tick = 1'b1;
                step();
                step();
                tick = 1'b0;
            end
`endif
            submit = 1'b1;
            entry = 4'h3;
            step();
            submit = 1'b0;
            exp_a--;
        end
        n_cmp++;
        if ({repair_fail, repair_done, q_Fail} !== 3'b101) begin
            n_bad++;
            $display("FAIL attempts_fail got %b want 101", {repair_fail, repair_done, q_Fail});
        end
        step();
        n_cmp++;
        if ({q_Idle, repair_fail} !== 2'b10) begin
            n_bad++;
            $display("FAIL attempts_idle got %b want 10", {q_Idle, repair_fail});
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        arm(4'h7);
        for (int k = 10; k >= 1; k--) begin
            n_cmp++;
            if (timer_left !== 4'(k) || !q_Armed || repair_fail) begin
                n_bad++;
                $display("FAIL timer_%0d got %0d armed%0d fail%0d want %0d 1 0", k, timer_left, q_Armed, repair_fail, k);
            end
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
        n_cmp++;
        if ({repair_fail, repair_done} !== 2'b10) begin
            n_bad++;
            $display("FAIL timeout_fail got %b want 10", {repair_fail, repair_done});
        end
        step();
        arm(4'h7);
        tick = 1'b1;
        repeat (9) step();
        submit = 1'b1;
        entry = 4'h7;
        step();
        tick = 1'b0;
        submit = 1'b0;
        n_cmp++;
        if ({repair_done, repair_fail} !== 2'b10) begin
            n_bad++;
            $display("FAIL tie_submit_tick got %b want 10", {repair_done, repair_fail});
        end
        step();
    endtask

    task automatic test_gameover();
        bit seen;
        apply_reset();
        arm(4'h9);
        gameover_ctrl = 1'b1;
        submit = 1'b1;
        entry = 4'h9;
        step();
        gameover_ctrl = 1'b0;
        submit = 1'b0;
        n_cmp++;
        if ({q_Idle, repair_done, repair_fail, display_hex} !== {3'b100, 4'h0}) begin
            n_bad++;
            $display("FAIL gameover_idle got idle%0d d%0d f%0d hex%h want 1 0 0 0", q_Idle, repair_done, repair_fail, display_hex);
        end
        n_cmp++;
        if ({attempts_left, timer_left} !== {2'd3, 4'd10}) begin
            n_bad++;
            $display("FAIL gameover_hold got a%0d t%0d want a3 t10", attempts_left, timer_left);
        end
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (repair_done || repair_fail) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL gameover_nopulse got pulse want none");
        end
        arm(4'hB);
        Reset = 1'b1;
        submit = 1'b1;
        entry = 4'hB;
        step();
        Reset = 1'b0;
        submit = 1'b0;
        n_cmp++;
        if ({q_Idle, busy, repair_done, repair_fail, attempts_left, timer_left, display_hex} !== {4'b1000, 10'd0}) begin
            n_bad++;
            $display("FAIL reset_mid got idle%0d b%0d d%0d f%0d a%0d t%0d hex%h want 1 0 0 0 0 0 0",
                     q_Idle, busy, repair_done, repair_fail, attempts_left, timer_left, display_hex);
        end
    endtask

`ifdef REPAIR_LOCKOUT_EN
    task automatic test_lockout();
        apply_reset();
        arm(4'h2);
        submit = 1'b1;
        entry = 4'hE;
        step();
        entry = 4'h2;
        step();
        submit = 1'b0;
        n_cmp++;
        if ({lockout, q_Armed, repair_done, attempts_left} !== {3'b110, 2'd2}) begin
            n_bad++;
            $display("FAIL lockout_ignore got l%0d armed%0d d%0d a%0d want 1 1 0 2", lockout, q_Armed, repair_done, attempts_left);
        end
        tick = 1'b1;
        step();
        step();
        tick = 1'b0;
        n_cmp++;
        if (lockout !== 1'b0) begin
            n_bad++;
            $display("FAIL lockout_clear got %0d want 0", lockout);
        end
        submit = 1'b1;
        step();
        submit = 1'b0;
        n_cmp++;
        if (repair_done !== 1'b1) begin
            n_bad++;
            $display("FAIL lockout_retry got %0d want 1", repair_done);
        end
        step();
    endtask
`endif

    task automatic test_random();
        logic [17:0] got;
        logic [17:0] exp;
        clear_in();
        Reset = 1'b1;
        step();
        m_ph = 0; m_chal = 0; m_att = 0; m_tmr = 0; m_lock = 0;
        for (int c = 0; c < 3000; c++) begin
            Reset         = ($urandom_range(0, 299) == 0);
            repair_req    = ($urandom_range(0, 3) == 0);
            challenge     = 4'($urandom);
            submit        = ($urandom_range(0, 2) == 0);
            entry         = $urandom_range(0, 1) ? 4'(m_chal) : 4'($urandom);
            tick          = ($urandom_range(0, 3) == 0);
            gameover_ctrl = ($urandom_range(0, 39) == 0);
            @(posedge Clk);
            model_step();
            #1;
            got = {busy, repair_done, repair_fail, attempts_left, timer_left,
                   display_hex, lockout, q_Idle, q_Armed, q_Pass, q_Fail};
            exp = {m_ph == 1, m_ph == 2, m_ph == 3, 2'(m_att), 4'(m_tmr),
                   (m_ph == 1) ? 4'(m_chal) : 4'h0, m_lock != 0,
                   m_ph == 0, m_ph == 1, m_ph == 2, m_ph == 3};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL random_cycle_%0d got %h want %h", c, got, exp);
            end
        end
        clear_in();
        Reset = 1'b0;
    endtask

    initial begin
        clear_in();
        Reset = 1'b1;
        test_reset();
        test_pass();
        test_attempts();
        test_timeout();
        test_gameover();
`ifdef REPAIR_LOCKOUT_EN
        test_lockout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/repair_code_responder.md
REPAIR_CODE_RESPONDER -- requirements
Module: repair_code_responder

Interface
REQ-001 SHALL have parameter MAX_ATTEMPTS, default 3, wrong entries allowed per repair (legal 1..3).
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 10, ticks allowed per repair (legal 1..15).
REQ-003 SHALL have port Clk  input  1  system clock (100 MHz); one clock; all state on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port repair_req  input  1  one-cycle pulse from room SM: room broken, start repair.
REQ-006 SHALL have port challenge  input  4  random hex code offered with repair_req.
REQ-007 SHALL have port entry  input  4  player code from switches {Sw3..Sw0}.
REQ-008 SHALL have port submit  input  1  one-cycle debounced pulse (BtnC single-clock pulse).
REQ-009 SHALL have port tick  input  1  one-cycle timebase enable (~1.5 Hz).
REQ-010 SHALL have port gameover_ctrl  input  1  game over; aborts repair.
REQ-011 SHALL have port busy  output  1  high in ARMED.
REQ-012 SHALL have port repair_done  output  1  one-cycle pulse: correct code.
REQ-013 SHALL have port repair_fail  output  1  one-cycle pulse: attempts or time exhausted.
REQ-014 SHALL have port attempts_left  output  2  remaining wrong entries allowed.
REQ-015 SHALL have port timer_left  output  4  remaining ticks.
REQ-016 SHALL have port display_hex  output  4  latched challenge for SSD; 0 outside ARMED.
REQ-017 SHALL have port lockout  output  1  submits currently ignored.
REQ-018 SHALL have ports q_Idle, q_Armed, q_Pass, q_Fail  output  1 each  one-hot state flags.

Function
REQ-019 SHALL implement one-hot states IDLE, ARMED, PASS, FAIL; all outputs registered or decoded from state registers only.
REQ-020 IDLE: repair_req=1 and gameover_ctrl=0 SHALL latch challenge into chal_reg, load attempts_left=MAX_ATTEMPTS, timer_left=TIMEOUT_TICKS, go ARMED next cycle.
REQ-021 repair_req SHALL be ignored in ARMED, PASS, FAIL (no relatch, no counter reload).
REQ-022 ARMED, submit=1, lockout=0, entry==chal_reg: SHALL go PASS next cycle.
REQ-023 ARMED, submit=1, lockout=0, entry!=chal_reg: attempts_left SHALL decrement; if it was 1, SHALL go FAIL instead.
REQ-024 ARMED, tick=1: timer_left SHALL decrement; if it was 1, SHALL go FAIL.
REQ-025 Same-cycle submit and tick: correct submit SHALL win (PASS); wrong submit with timer expiry SHALL go FAIL with one repair_fail pulse.
REQ-026 PASS and FAIL SHALL last exactly one cycle, then IDLE; repair_done high only in PASS, repair_fail high only in FAIL.
REQ-027 Latency: submit at cycle N SHALL give repair_done/repair_fail at cycle N+1.
REQ-028 gameover_ctrl=1 in any state SHALL force IDLE next cycle with no repair_done/repair_fail pulse; counters hold.
REQ-029 Counters SHALL never wrap below 0; submit/tick in IDLE, PASS, FAIL SHALL have no effect.

Reset
REQ-030 Reset=1 at a clock edge SHALL force IDLE, chal_reg=0, attempts_left=0, timer_left=0, lockout counter=0; all pulse outputs 0, q_Idle=1.
REQ-031 Reset mid-repair SHALL abandon it with no pulse; Reset dominates all other inputs.

Configuration
REQ-032 Macro REPAIR_LOCKOUT_EN defined: wrong submit in ARMED (not causing FAIL) SHALL load a 2-bit lockout counter with 2; while nonzero, lockout=1, submits ignored and not counted; counter decrements on tick; cleared on leaving ARMED.
REQ-033 Macro REPAIR_LOCKOUT_EN undefined: no lockout counter; lockout SHALL be tied 0; immediate retry allowed.

Verification
REQ-034 Defaults: repair_req with challenge=4'hA; submit entry=4'hA 3 cycles later -> repair_done pulse next cycle, q_Idle one cycle after.
REQ-035 challenge=4'h5; three submits entry=4'h3 (ticks between if lockout built) -> attempts_left 3,2,1, then repair_fail one cycle after third submit.
REQ-036 challenge=4'h7, no submits, 10 ticks -> timer_left 10..1, repair_fail cycle after 10th tick; same-cycle correct submit on 10th tick -> repair_done only.
REQ-037 gameover_ctrl=1 while ARMED -> IDLE next cycle, no pulses, display_hex=0; Reset mid-ARMED -> all outputs at reset values.
REQ-038 REPAIR_LOCKOUT_EN defined: wrong submit then immediate correct submit -> ignored, lockout=1; after 2 ticks correct submit -> repair_done.
